// File: rtl/fulladd_checker_if.sv
// Operand/response bundle between the exhaustive checker and a 1-bit full adder.
// The checker drives x/y/cin (master); the adder under test answers with s/cout (slave).
interface fulladd_checker_if;
    logic x;
    logic y;
    logic cin;
    logic s;
    logic cout;

    modport master (output x, output y, output cin, input s, input cout);
    modport slave  (input x, input y, input cin, output s, output cout);
endinterface

// File: rtl/fulladd_checker.sv
// Exhaustive on-chip tester for a 1-bit full adder: walks all eight operand
// combinations, samples the response SETTLE cycles later and reports the results.
module fulladd_checker #(
    parameter int SETTLE = 2,
    parameter int ERRW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    fulladd_checker_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRW-1:0]     err_cnt,
    output logic [7:0]          fail_vec,
    output logic [2:0]          vec_idx,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0]      LAST_CNT = 4'(SETTLE - 1);
    localparam logic [ERRW-1:0] ERR_MAX  = '1;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] next_idx;
    logic       exp_s;
    logic       exp_cout;
    logic       mism;

    // Operand order is {x, y, cin}: single ones first, then pairs, then all ones.
    function automatic logic [2:0] vec_ops(input logic [2:0] k);
        case (k)
            3'd0:    vec_ops = 3'b000;
            3'd1:    vec_ops = 3'b100;
            3'd2:    vec_ops = 3'b010;
            3'd3:    vec_ops = 3'b001;
            3'd4:    vec_ops = 3'b110;
            3'd5:    vec_ops = 3'b101;
            3'd6:    vec_ops = 3'b011;
            default: vec_ops = 3'b111;
        endcase
    endfunction

    always_comb begin
        next_idx = vec_idx + 3'd1;
        exp_s    = bus.x ^ bus.y ^ bus.cin;
        exp_cout = (bus.x & bus.y) | (bus.x & bus.cin) | (bus.y & bus.cin);
        mism     = (bus.s != exp_s) || (bus.cout != exp_cout);
    end

    assign fsm_state = state;

    // The compare happens on the edge that leaves DRIVE, SETTLE cycles after the
    // operands changed; SAMPLE is the one extra cycle before the next vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            cnt                    <= 4'd0;
            {bus.x, bus.y, bus.cin} <= 3'b000;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            pass                   <= 1'b0;
            err_cnt                <= '0;
            fail_vec               <= 8'h00;
            vec_idx                <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state                  <= DRIVE;
                        cnt                    <= 4'd0;
                        {bus.x, bus.y, bus.cin} <= vec_ops(3'd0);
                        busy                   <= 1'b1;
                        pass                   <= 1'b0;
                        err_cnt                <= '0;
                        fail_vec               <= 8'h00;
                        vec_idx                <= 3'd0;
                    end
                end
                DRIVE: begin
                    if (cnt == LAST_CNT) begin
                        if (mism) begin
                            fail_vec[vec_idx] <= 1'b1;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                        if (vec_idx == 3'd7) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mism && (fail_vec == 8'h00);
                        end else begin
                            state <= SAMPLE;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    state                  <= DRIVE;
                    cnt                    <= 4'd0;
                    vec_idx                <= next_idx;
                    {bus.x, bus.y, bus.cin} <= vec_ops(next_idx);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fulladd_checker.sv
// Directed bench for fulladd_checker with several behavioural full-adder models
// (ideal, stuck, inverted, pipelined) and hand-computed expected results.
module tb_fulladd_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_bc = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;

    always #5 clk = ~clk;

    fulladd_checker_if bus_a ();
    fulladd_checker_if bus_b ();
    fulladd_checker_if bus_c ();

    logic       busy_a, done_a, pass_a;
    logic [3:0] err_a;
    logic [7:0] fail_a;
    logic [2:0] idx_a;
    logic [1:0] st_a;
    logic       busy_b, done_b, pass_b;
    logic [1:0] err_b;
    logic [7:0] fail_b;
    logic [2:0] idx_b;
    logic [1:0] st_b;
    logic       busy_c, done_c, pass_c;
    logic [3:0] err_c;
    logic [7:0] fail_c;
    logic [2:0] idx_c;
    logic [1:0] st_c;

    fulladd_checker #(.SETTLE(2), .ERRW(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a.master),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .fail_vec(fail_a), .vec_idx(idx_a), .fsm_state(st_a));

    fulladd_checker #(.SETTLE(2), .ERRW(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_bc), .bus(bus_b.master),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .fail_vec(fail_b), .vec_idx(idx_b), .fsm_state(st_b));

    fulladd_checker #(.SETTLE(1), .ERRW(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_bc), .bus(bus_c.master),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
        .fail_vec(fail_c), .vec_idx(idx_c), .fsm_state(st_c));

    // Adder models: returns {s, cout}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic cin);
        fa = {x ^ y ^ cin, (x & y) | (x & cin) | (y & cin)};
    endfunction

    logic [1:0] a_ideal, a_r1, a_resp, b_ideal, c_r1, c_r2;
    assign a_ideal = fa(bus_a.x, bus_a.y, bus_a.cin);
    assign b_ideal = fa(bus_b.x, bus_b.y, bus_b.cin);

    always @(posedge clk) begin
        a_r1 <= a_ideal;
        c_r1 <= fa(bus_c.x, bus_c.y, bus_c.cin);
        c_r2 <= c_r1;
    end

    always_comb begin
        a_resp = a_ideal;
        case (mode)
            1:       a_resp = {a_ideal[1], 1'b0};
            2:       a_resp = {~a_ideal[1], a_ideal[0]};
            3:       a_resp = a_r1;
            default: a_resp = a_ideal;
        endcase
    end

    assign bus_a.s    = a_resp[1];
    assign bus_a.cout = a_resp[0];
    assign bus_b.s    = ~b_ideal[1];
    assign bus_b.cout = b_ideal[0];
    assign bus_c.s    = c_r2[1];
    assign bus_c.cout = c_r2[0];

    logic [2:0] exp_ops [8] = '{3'b000, 3'b100, 3'b010, 3'b001,
                                3'b110, 3'b101, 3'b011, 3'b111};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One run on instance A; returns the cycle (T0 = 1) on which done is seen.
    task automatic run_a(input bit check_ops, output int cyc);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            @(negedge clk);
            if (check_ops && cyc <= 22 && (cyc - 1) % 3 == 0) begin
                check("ops", {29'd0, bus_a.x, bus_a.y, bus_a.cin}, {29'd0, exp_ops[(cyc - 1) / 3]});
                check("vec_idx", {29'd0, idx_a}, (cyc - 1) / 3);
            end
            if (done_a) break;
            @(posedge clk);
            cyc++;
        end
        if (!done_a) check("done_timeout", {31'd0, done_a}, 32'd1);
    endtask

    task automatic check_a_result(input string tag, input int cyc, input logic p,
                                  input logic [3:0] e, input logic [7:0] f);
        check({tag, "_done_cyc"}, cyc, 32'd24);
        check({tag, "_busy_at_done"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass_a}, {31'd0, p});
        check({tag, "_err"}, {28'd0, err_a}, {28'd0, e});
        check({tag, "_fail_vec"}, {24'd0, fail_a}, {24'd0, f});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done_a}, 32'd0);
    endtask

    initial begin
        int  cyc;
        int  cb, cc, ndone, d1, d2;
        bit  got_b, got_c, seen_done;

        // Reset state
        #1;
        check("rst_ops", {29'd0, bus_a.x, bus_a.y, bus_a.cin}, 32'd0);
        check("rst_flags", {29'd0, busy_a, done_a, pass_a}, 32'd0);
        check("rst_err_fail", {20'd0, err_a, fail_a}, 32'd0);
        check("rst_idx_state", {27'd0, idx_a, st_a}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ERRW=2 with inverted s, and SETTLE=1 with two registered stages
        start_bc = 1'b1;
        @(posedge clk);
        #1 start_bc = 1'b0;
        cyc = 1; got_b = 0; got_c = 0; cb = 0; cc = 0;
        while (cyc < 100 && !(got_b && got_c)) begin
            @(negedge clk);
            if (done_b && !got_b) begin got_b = 1; cb = cyc; end
            if (done_c && !got_c) begin got_c = 1; cc = cyc; end
            @(posedge clk);
            cyc++;
        end
        check("b_done_cyc", cb, 32'd24);
        check("b_err_sat", {30'd0, err_b}, 32'd3);
        check("b_fail_vec", {24'd0, fail_b}, 32'hFF);
        check("b_pass", {31'd0, pass_b}, 32'd0);
        check("c_done_cyc", cc, 32'd16);
        check("c_err", {28'd0, err_c}, 32'd3);
        check("c_fail_vec", {24'd0, fail_c}, 32'h92);
        check("c_pass", {31'd0, pass_c}, 32'd0);

        // Instance A with each adder model
        mode = 0; run_a(1'b1, cyc); check_a_result("ideal", cyc, 1'b1, 4'd0, 8'h00);
        mode = 1; run_a(1'b0, cyc); check_a_result("cout0", cyc, 1'b0, 4'd4, 8'hF0);
        mode = 2; run_a(1'b0, cyc); check_a_result("sinv", cyc, 1'b0, 4'd8, 8'hFF);
        mode = 3; run_a(1'b0, cyc); check_a_result("reg1", cyc, 1'b1, 4'd0, 8'h00);

        // start held high for 60 cycles: back-to-back runs
        mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        ndone = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done_a) begin
                ndone++;
                if (ndone == 1) d1 = c;
                if (ndone == 2) d2 = c;
            end
            if (c == 25) check("b2b_busy_no_gap", {31'd0, busy_a}, 32'd1);
            if (c < 60) @(posedge clk);
        end
        start_a = 1'b0;
        check("b2b_done_count", ndone, 32'd2);
        check("b2b_done1", d1, 32'd24);
        check("b2b_done2", d2, 32'd48);

        // Reset while vector 3 is driven
        cyc = 0;
        while (idx_a != 3'd3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_idx", {29'd0, idx_a}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ops", {29'd0, bus_a.x, bus_a.y, bus_a.cin}, 32'd0);
        check("rst_mid_flags", {29'd0, busy_a, done_a, pass_a}, 32'd0);
        check("rst_mid_err_fail", {20'd0, err_a, fail_a}, 32'd0);
        check("rst_mid_idx0", {29'd0, idx_a}, 32'd0);
        seen_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 3) rst_n = 1'b1;
            if (done_a) seen_done = 1;
        end
        check("rst_no_done", {31'd0, seen_done}, 32'd0);
        check("rst_idle_busy", {31'd0, busy_a}, 32'd0);
        run_a(1'b1, cyc);
        check_a_result("post_rst", cyc, 1'b1, 4'd0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fulladd_checker.md
# fulladd_checker

Synthesizable exhaustive tester for a 1-bit full adder: on `start` it drives all eight (x, y, cin) combinations into an attached full-adder DUT and samples (s, cout) after a settle delay. It compares each response against the full-adder truth table and reports a per-vector failure map, an error count and a pass flag. It sits beside the full-adder implementations as the receiving, checking end of the x/y/cin -> s/cout interface, usable on-chip or in simulation without a behavioural bench.

## Interface
Parameters:
- `SETTLE`, default 2: wait cycles between operand change and response sample; legal range 1..15.
- `ERRW`, default 4: width of `err_cnt`; legal range 1..8.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a test run; sampled only while idle.
- `x`, `y`, `cin`  out  1 each  registered operands to the DUT.
- `s`, `cout`  in  1 each  DUT responses.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  high when the last completed run had zero errors.
- `err_cnt`  out  ERRW  mismatching vectors in the last or current run; saturates.
- `fail_vec`  out  8  bit k set if vector k mismatched.
- `vec_idx`  out  3  index of the vector currently driven.

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 -> DRIVE.
  - DRIVE/WAIT: operands for `vec_idx` are held. A settle counter runs 0..SETTLE.
  - SAMPLE: compare responses. If `vec_idx`=7 -> IDLE with `done`, else increment `vec_idx` and return to DRIVE.
- Vector order, k = 0..7, as (x,y,cin): 000, 100, 010, 001, 110, 101, 011, 111.
- Expected responses: s = x^y^cin; cout = (x&y)|(x&cin)|(y&cin).
- A vector is a mismatch if either bit differs from expected. A mismatch sets `fail_vec[k]` and increments `err_cnt`.
- `err_cnt` saturates at 2^ERRW-1 and never wraps. `fail_vec` always records all 8 vectors.
- Accepting `start` clears `err_cnt`, `fail_vec` and `pass`, and loads vector 0.
- `pass` = (no mismatches) is updated on the `done` cycle and held until the next `start` is accepted.
- `start` while `busy`=1 is ignored; there is no queuing.
- `s`/`cout` are ignored outside sample edges.
- Reset values (asynchronous, any time): `x`=`y`=`cin`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, `vec_idx`=0, state IDLE.
- Reset mid-run aborts the run: no `done` pulse and no partial results retained.

## Timing
- `start` is sampled high at edge T0. From T0: `busy`=1, `vec_idx`=0, operands = vector 0.
- Vector k is driven from edge T0+k·(SETTLE+1) until edge T0+(k+1)·(SETTLE+1).
- `s`/`cout` for vector k are sampled at edge T0+(k+1)·(SETTLE+1)-1, i.e. SETTLE cycles after the operands change. A DUT with combinational or up to SETTLE-1 registered latency passes.
- Last sample lands at edge T0+8·(SETTLE+1)-1. From that edge, `done`=1 for exactly one cycle, `busy`=0, and final `pass`/`err_cnt`/`fail_vec` are valid.
- Total run with SETTLE=2: 24 cycles from `start` to `done`.
- Operands hold vector 7 after the run until the next start.
- `start`=1 during the `done` cycle is accepted (state is IDLE). With `start` held high, runs are back-to-back with no idle gap; `done` pulses once per run.
- `done` and `busy` are never high in the same cycle, except when a new `start` is accepted on the `done` cycle: then `busy` rises on the following edge.

## Test plan
- Ideal combinational DUT, SETTLE=2, single `start` pulse:
  - operands step through 000,100,010,001,110,101,011,111 every 3 cycles;
  - `done` 24 cycles after `start`;
  - results `pass`=1, `err_cnt`=0, `fail_vec`=8'h00.
- DUT with `cout` stuck at 0 -> `fail_vec`=8'hF0, `err_cnt`=4, `pass`=0.
- DUT with `s` inverted:
  - ERRW=4 -> `fail_vec`=8'hFF, `err_cnt`=8;
  - ERRW=2 -> `err_cnt`=3 (saturated), `fail_vec`=8'hFF.
- DUT with one registered stage:
  - SETTLE=2 -> `pass`=1;
  - SETTLE=1 with two registered stages -> mismatches reported, `pass`=0.
- Hold `start` high for 60 cycles, SETTLE=2:
  - two full runs, `done` at +24 and +48, no gap between them;
  - `start` pulses mid-run are ignored.
- Assert `rst_n`=0 while `vec_idx`=3 -> all outputs 0 immediately and no `done`. A fresh `start` then completes a full 24-cycle run with correct results.
